// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared FSM states, IF/ID operations and fetch constants
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    typedef enum logic [1:0] {IFID_HOLD, IFID_LOAD, IFID_FLUSH, IFID_BUBBLE} ifid_op_t;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_ctrl_ifid.sv
// ifid_reg: IF/ID pipeline register with hold, load, flush and bubble operations
module ifid_reg
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  ifid_op_t        op,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= XLEN'(NOP);
            pc    <= '0;
        end else begin
            case (op)
                IFID_LOAD: begin
                    valid <= 1'b1;
                    instr <= load_instr;
                    pc    <= load_pc;
                end
                IFID_FLUSH: begin
                    valid <= 1'b0;
                    instr <= XLEN'(NOP);
                end
                IFID_BUBBLE: valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch FSM driving the PC update, memory request and IF/ID register
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_current,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            hazard_stall,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] jump_address,
    output logic            register_write,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic            ifid_valid
);

    state_t          state, next;
    ifid_op_t        op;
    logic [7:0]      cnt;
    logic            redirect, timeout;
    logic [XLEN-1:0] target;

    assign imem_addr = pc_current;
    assign redirect  = branch_taken | jump;
    // Branch (EX) is older than jump (ID), so it wins; targets are word aligned.
    assign target    = (branch_taken ? branch_target : jump_target) & ~XLEN'(3);
    assign timeout   = cnt == 8'(DRAIN_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            cnt   <= '0;
        end else begin
            state <= next;
            cnt   <= (state == DRAIN) ? cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        next           = state;
        op             = IFID_HOLD;
        imem_req       = 1'b0;
        register_write = 1'b1;
        jump_address   = pc_current;
        if (!rst) begin
            case (state)
                BOOT: next = FETCH;
                FETCH: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        jump_address   = target;
                        register_write = 1'b0;
                        op             = IFID_FLUSH;
                        next           = imem_ready ? FETCH : DRAIN;
                    end else if (!hazard_stall && imem_ready) begin
                        jump_address   = pc_current + XLEN'(PC_INC);
                        register_write = 1'b0;
                        op             = IFID_LOAD;
                    end else if (!hazard_stall) begin
                        op = IFID_BUBBLE;
                    end
                end
                DRAIN: begin
                    op = IFID_BUBBLE;
                    if (redirect) begin
                        jump_address   = target;
                        register_write = 1'b0;
                    end else if (imem_ready || timeout) begin
                        next = FETCH;
                    end
                end
                default: next = BOOT;
            endcase
        end
    end

    ifid_reg #(.XLEN(XLEN)) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .load_instr (imem_rdata),
        .load_pc    (pc_current),
        .instr      (ifid_instr),
        .pc         (ifid_pc),
        .valid      (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, multi-cycle corner sequences and a randomized run against a reference model
module tb_fetch_ctrl;

    localparam logic [31:0] NOP_W   = 32'h0000_0013;
    localparam int          TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst, branch_taken, jump, hazard_stall, imem_ready;
    logic        imem_req, register_write, ifid_valid;
    logic [31:0] pc_current, branch_target, jump_target, imem_rdata;
    logic [31:0] imem_addr, jump_address, ifid_instr, ifid_pc;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .pc_current     (pc_current),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .hazard_stall   (hazard_stall),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .jump_address   (jump_address),
        .register_write (register_write),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_valid     (ifid_valid)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        stall;
        logic        ready;
        logic [31:0] rdata;
        logic        req;
        logic        rw;
        logic [31:0] ja;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
    } vec_t;

    int passed = 0;
    int total  = 0;

    // Reference model: phase 0=boot, 1=fetching, 2=draining; dwell counts draining cycles.
    int          m_phase = 0;
    int          m_dwell = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = NOP_W;
    logic [31:0] m_pc    = 32'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic br, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic stall, input logic ready,
                                input logic [31:0] rdata, input logic req, input logic rw, input logic [31:0] ja,
                                input logic valid, input logic [31:0] instr, input logic [31:0] ipc);
        vec_t v;
        v.rst = r; v.pc = pc; v.br = br; v.bt = bt; v.j = j; v.jt = jt; v.stall = stall;
        v.ready = ready; v.rdata = rdata; v.req = req; v.rw = rw; v.ja = ja;
        v.valid = valid; v.instr = instr; v.ipc = ipc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; pc_current = v.pc; branch_taken = v.br; branch_target = v.bt;
        jump = v.j; jump_target = v.jt; hazard_stall = v.stall; imem_ready = v.ready; imem_rdata = v.rdata;
    endtask

    // Called at posedge+1: checks combinational outputs mid-cycle, then the registers after the edge.
    task automatic apply(input vec_t v, input string tag);
        drive(v);
        #2;
        chk({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, v.req});
        chk({tag, ".register_write"}, {31'b0, register_write}, {31'b0, v.rw});
        chk({tag, ".jump_address"}, jump_address, v.ja);
        chk({tag, ".imem_addr"}, imem_addr, v.pc);
        @(posedge clk);
        #1;
        chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, v.valid});
        chk({tag, ".ifid_instr"}, ifid_instr, v.instr);
        chk({tag, ".ifid_pc"}, ifid_pc, v.ipc);
    endtask

    task automatic model_step(inout vec_t v);
        logic        redir;
        logic [31:0] tgt;
        redir = v.br | v.j;
        tgt   = (v.br ? v.bt : v.jt) & 32'hFFFF_FFFC;
        v.req = 1'b0;
        v.rw  = 1'b1;
        v.ja  = v.pc;
        if (v.rst) begin
            m_phase = 0; m_dwell = 0; m_valid = 1'b0; m_instr = NOP_W; m_pc = 32'h0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            v.req = 1'b1;
            if (redir) begin
                v.ja = tgt; v.rw = 1'b0; m_valid = 1'b0; m_instr = NOP_W;
                if (!v.ready) begin m_phase = 2; m_dwell = 0; end
            end else if (!v.stall && v.ready) begin
                v.ja = v.pc + 32'd4; v.rw = 1'b0; m_instr = v.rdata; m_pc = v.pc; m_valid = 1'b1;
            end else if (!v.stall) begin
                m_valid = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
            m_dwell++;
            if (redir) begin
                v.ja = tgt; v.rw = 1'b0;
            end else if (v.ready || (m_dwell % 256) == TIMEOUT) begin
                m_phase = 1;
            end
        end
        v.valid = m_valid; v.instr = m_instr; v.ipc = m_pc;
    endtask

    vec_t table_v[$];

    initial begin
        vec_t v;
        logic [31:0] pc_reg;
        int n;
        //                 rst pc            br bt         j  jt         st rdy rdata         req rw ja            vld instr         ipc
        table_v.push_back(mk(1, 32'h0,        0, 32'h0,     0, 32'h0,     0, 1, 32'hAAAA0001, 0, 1, 32'h0,        0, NOP_W,        32'h0));
        table_v.push_back(mk(0, 32'h0,        0, 32'h0,     0, 32'h0,     0, 1, 32'hAAAA0001, 0, 1, 32'h0,        0, NOP_W,        32'h0));
        table_v.push_back(mk(0, 32'h0,        0, 32'h0,     0, 32'h0,     0, 1, 32'hAAAA0001, 1, 0, 32'h4,        1, 32'hAAAA0001, 32'h0));
        table_v.push_back(mk(0, 32'h4,        0, 32'h0,     0, 32'h0,     1, 1, 32'hBBBB0002, 1, 1, 32'h4,        1, 32'hAAAA0001, 32'h0));
        table_v.push_back(mk(0, 32'h4,        0, 32'h0,     0, 32'h0,     1, 1, 32'hBBBB0002, 1, 1, 32'h4,        1, 32'hAAAA0001, 32'h0));
        table_v.push_back(mk(0, 32'h4,        0, 32'h0,     0, 32'h0,     1, 1, 32'hBBBB0002, 1, 1, 32'h4,        1, 32'hAAAA0001, 32'h0));
        table_v.push_back(mk(0, 32'h4,        0, 32'h0,     0, 32'h0,     0, 1, 32'hBBBB0002, 1, 0, 32'h8,        1, 32'hBBBB0002, 32'h4));
        table_v.push_back(mk(0, 32'hFFFFFFFC, 0, 32'h0,     0, 32'h0,     0, 1, 32'hCCCC0003, 1, 0, 32'h0,        1, 32'hCCCC0003, 32'hFFFFFFFC));
        table_v.push_back(mk(0, 32'h0,        0, 32'h0,     1, 32'h203,   0, 1, 32'h0,        1, 0, 32'h200,      0, NOP_W,        32'hFFFFFFFC));
        table_v.push_back(mk(0, 32'h200,      0, 32'h0,     0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h200,      0, NOP_W,        32'hFFFFFFFC));
        table_v.push_back(mk(0, 32'h200,      1, 32'h100,   1, 32'h200,   0, 0, 32'h0,        1, 0, 32'h100,      0, NOP_W,        32'hFFFFFFFC));
        table_v.push_back(mk(0, 32'h100,      0, 32'h0,     0, 32'h0,     0, 0, 32'h0,        0, 1, 32'h100,      0, NOP_W,        32'hFFFFFFFC));
        table_v.push_back(mk(0, 32'h100,      0, 32'h0,     0, 32'h0,     0, 1, 32'hDDDD0004, 0, 1, 32'h100,      0, NOP_W,        32'hFFFFFFFC));
        table_v.push_back(mk(0, 32'h100,      0, 32'h0,     0, 32'h0,     0, 1, 32'hEEEE0005, 1, 0, 32'h104,      1, 32'hEEEE0005, 32'h100));

        drive(table_v[0]);
        @(posedge clk);
        #1;
        foreach (table_v[i]) apply(table_v[i], $sformatf("vec%0d", i));

        // DRAIN with no response: FETCH (imem_req=1) must return after exactly TIMEOUT cycles.
        apply(mk(0, 32'h104, 0, 32'h0, 1, 32'h300, 0, 0, 32'h0, 1, 0, 32'h300, 0, NOP_W, 32'h100), "to_drain");
        drive(mk(0, 32'h300, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        n = 0;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (imem_req) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout_cycles", n, TIMEOUT);
        @(posedge clk);
        #1;

        // Redirect inside DRAIN holds DRAIN even with a response present.
        apply(mk(0, 32'h300, 0, 32'h0,   1, 32'h400, 0, 0, 32'h0,        1, 0, 32'h400, 0, NOP_W,        32'h100), "drain_enter");
        apply(mk(0, 32'h400, 1, 32'h500, 0, 32'h0,   0, 1, 32'h0,        0, 0, 32'h500, 0, NOP_W,        32'h100), "drain_redirect");
        apply(mk(0, 32'h500, 0, 32'h0,   0, 32'h0,   0, 1, 32'h0,        0, 1, 32'h500, 0, NOP_W,        32'h100), "drain_exit");
        apply(mk(0, 32'h500, 0, 32'h0,   0, 32'h0,   0, 1, 32'h12345678, 1, 0, 32'h504, 1, 32'h12345678, 32'h500), "after_drain");

        // Reset mid-DRAIN and mid-stall overrides everything else.
        apply(mk(0, 32'h504, 0, 32'h0,   1, 32'h600, 0, 0, 32'h0,        1, 0, 32'h600, 0, NOP_W,        32'h500), "rst_drain_enter");
        apply(mk(1, 32'h600, 1, 32'h700, 0, 32'h0,   0, 1, 32'h0,        0, 1, 32'h600, 0, NOP_W,        32'h0),   "rst_in_drain");
        apply(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h11110000, 0, 1, 32'h0,   0, NOP_W,        32'h0),   "boot_again");
        apply(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h22220000, 1, 0, 32'h4,   1, 32'h22220000, 32'h0),   "load_again");
        apply(mk(0, 32'h4,   0, 32'h0,   0, 32'h0,   1, 1, 32'h33330000, 1, 1, 32'h4,   1, 32'h22220000, 32'h0),   "stall_again");
        apply(mk(1, 32'h4,   0, 32'h0,   1, 32'h800, 1, 1, 32'h44440000, 0, 1, 32'h4,   0, NOP_W,        32'h0),   "rst_in_stall");

        // Randomized run; the bench plays the PC register, loading jump_address when register_write=0.
        pc_reg = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            v.rst   = ($urandom_range(0, 99) == 0);
            v.pc    = pc_reg;
            v.br    = ($urandom_range(0, 7) == 0);
            v.bt    = $urandom;
            v.j     = ($urandom_range(0, 7) == 0);
            v.jt    = $urandom;
            v.stall = ($urandom_range(0, 3) == 0);
            v.ready = ($urandom_range(0, 9) < 3);
            v.rdata = $urandom;
            model_step(v);
            apply(v, $sformatf("rand%0d", c));
            if (!v.rw) pc_reg = v.ja;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
